// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// The BREAK state only exists when UART_TX_BREAK_EN is defined.
package uart_pkg;

  localparam int PAYLOAD_W = 9;

  // r_data_len encodings
  localparam logic [2:0] LEN_5 = 3'd0;
  localparam logic [2:0] LEN_6 = 3'd1;
  localparam logic [2:0] LEN_7 = 3'd2;
  localparam logic [2:0] LEN_8 = 3'd3;
  localparam logic [2:0] LEN_9 = 3'd4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_BREAK_EN
    ,
    BREAK
`endif
  } tx_state_e;

  // Reserved length codes fall back to 8 data bits.
  function automatic logic [3:0] data_bits(input logic [2:0] len);
    case (len)
      LEN_5:   data_bits = 4'd5;
      LEN_6:   data_bits = 4'd6;
      LEN_7:   data_bits = 4'd7;
      LEN_8:   data_bits = 4'd8;
      LEN_9:   data_bits = 4'd9;
      default: data_bits = 4'd8;
    endcase
  endfunction

  function automatic logic [PAYLOAD_W-1:0] payload_mask(input logic [3:0] nbits);
    payload_mask = 9'h1FF >> (4'd9 - nbits);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter; bit_end is a registered tick in the last clock of each bit.
// bit_end_nxt exposes its D input so the engine can register outputs aligned to that clock.
module uart_baud_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 uart_clk,
  input  logic                 uart_rst,
  input  logic                 load,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 bit_end,
  output logic                 bit_end_nxt
);

  logic [DIV_WIDTH-1:0] cnt, cnt_nxt;

  // Reload at every bit boundary, so an all-ones divisor never wraps.
  always_comb begin
    cnt_nxt = cnt;
    if (load)
      cnt_nxt = div;
    else if (run)
      cnt_nxt = (cnt == '0) ? div : cnt - DIV_WIDTH'(1);
  end

  assign bit_end_nxt = (load | run) && (cnt_nxt == '0);

  always_ff @(posedge uart_clk or posedge uart_rst) begin
    if (uart_rst) begin
      cnt     <= '0;
      bit_end <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      bit_end <= bit_end_nxt;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops TX FIFO words and serialises them on txd with registered outputs.
// Define UART_TX_BREAK_EN to send a break for words with the control bit set.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int FIFO_DW   = 10
) (
  input  logic                 uart_clk,
  input  logic                 uart_rst,
  input  logic                 tx_fifo_empty,
  input  logic [FIFO_DW-1:0]   tx_fifo_rdata,
  output logic                 tx_fifo_re,
  input  logic                 r_tx_en,
  input  logic [DIV_WIDTH-1:0] r_baud_div,
  input  logic [2:0]           r_data_len,
  input  logic                 r_parity_en,
  input  logic                 r_parity_odd,
  input  logic                 r_stop2,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 int_status_tx_done
);

  tx_state_e            state, state_nxt;
  logic [PAYLOAD_W-1:0] shift, shift_nxt;
  logic [3:0]           bit_cnt, bit_cnt_nxt;
  logic                 stop_idx, stop_idx_nxt;
  logic                 txd_nxt;
  logic                 done_nxt;

  logic [3:0]           sh_nbits;
  logic                 sh_par_en, sh_par_bit, sh_stop2;
  logic [DIV_WIDTH-1:0] sh_div;

  logic                 brk_word;
  logic                 bit_end, bit_end_nxt;
  logic                 baud_load, baud_run;
  logic [DIV_WIDTH-1:0] baud_div;

`ifdef UART_TX_BREAK_EN
  assign brk_word = tx_fifo_rdata[FIFO_DW-1];
`else
  logic unused_ctl;
  assign unused_ctl = ^tx_fifo_rdata[FIFO_DW-1:PAYLOAD_W];
  assign brk_word   = 1'b0;
`endif

  assign baud_load = (state == LOAD);
  // LOAD seeds the counter from the live register, later bits use the snapshot.
  assign baud_div  = baud_load ? r_baud_div : sh_div;

  always_comb begin
    baud_run = 1'b0;
    case (state)
      START, DATA, PARITY, STOP: baud_run = 1'b1;
`ifdef UART_TX_BREAK_EN
      BREAK:                     baud_run = 1'b1;
`endif
      default:                   baud_run = 1'b0;
    endcase
  end

  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .uart_clk    (uart_clk),
    .uart_rst    (uart_rst),
    .load        (baud_load),
    .run         (baud_run),
    .div         (baud_div),
    .bit_end     (bit_end),
    .bit_end_nxt (bit_end_nxt)
  );

  // txd_nxt is the line level for the state being entered, so txd tracks state exactly.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift;
    bit_cnt_nxt  = bit_cnt;
    stop_idx_nxt = stop_idx;
    txd_nxt      = txd;
    case (state)
      IDLE: begin
        txd_nxt = 1'b1;
        if (r_tx_en && !tx_fifo_empty)
          state_nxt = FETCH;
      end
      FETCH: begin
        txd_nxt   = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        shift_nxt    = tx_fifo_rdata[PAYLOAD_W-1:0];
        bit_cnt_nxt  = 4'd0;
        stop_idx_nxt = 1'b0;
        txd_nxt      = 1'b0;
        state_nxt    = START;
`ifdef UART_TX_BREAK_EN
        if (brk_word) begin
          // low for start + data + parity + stops, counted down to zero
          bit_cnt_nxt = data_bits(r_data_len) + {3'b000, r_parity_en} + (r_stop2 ? 4'd2 : 4'd1);
          state_nxt   = BREAK;
        end
`endif
      end
      START: begin
        if (bit_end) begin
          txd_nxt   = shift[0];
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == sh_nbits - 4'd1) begin
            if (sh_par_en) begin
              txd_nxt   = sh_par_bit;
              state_nxt = PARITY;
            end else begin
              txd_nxt   = 1'b1;
              state_nxt = STOP;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 4'd1;
            shift_nxt   = {1'b0, shift[PAYLOAD_W-1:1]};
            txd_nxt     = shift[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          txd_nxt   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        txd_nxt = 1'b1;
        if (bit_end) begin
          if (stop_idx != sh_stop2)
            stop_idx_nxt = 1'b1;
          else
            state_nxt = IDLE;
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        txd_nxt = 1'b0;
        if (bit_end) begin
          if (bit_cnt == 4'd0) begin
            txd_nxt   = 1'b1;
            state_nxt = STOP;
          end else begin
            bit_cnt_nxt = bit_cnt - 4'd1;
          end
        end
      end
`endif
      default: begin
        txd_nxt   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // High during the final clock of the last stop bit.
  assign done_nxt = (state_nxt == STOP) && (stop_idx_nxt == sh_stop2) && bit_end_nxt;

  always_ff @(posedge uart_clk or posedge uart_rst) begin
    if (uart_rst) begin
      state              <= IDLE;
      shift              <= '0;
      bit_cnt            <= '0;
      stop_idx           <= 1'b0;
      txd                <= 1'b1;
      tx_fifo_re         <= 1'b0;
      tx_busy            <= 1'b0;
      int_status_tx_done <= 1'b0;
    end else begin
      state              <= state_nxt;
      shift              <= shift_nxt;
      bit_cnt            <= bit_cnt_nxt;
      stop_idx           <= stop_idx_nxt;
      txd                <= txd_nxt;
      tx_fifo_re         <= (state_nxt == FETCH);
      tx_busy            <= (state_nxt != IDLE);
      int_status_tx_done <= done_nxt;
    end
  end

  // Frame config is frozen at LOAD so register writes only affect later frames.
  always_ff @(posedge uart_clk or posedge uart_rst) begin
    if (uart_rst) begin
      sh_nbits   <= '0;
      sh_par_en  <= 1'b0;
      sh_par_bit <= 1'b0;
      sh_stop2   <= 1'b0;
      sh_div     <= '0;
    end else if (state == LOAD) begin
      sh_nbits   <= data_bits(r_data_len);
      sh_par_en  <= r_parity_en;
      sh_par_bit <= ^(tx_fifo_rdata[PAYLOAD_W-1:0] & payload_mask(data_bits(r_data_len))) ^ r_parity_odd;
      sh_stop2   <= r_stop2 & ~brk_word;
      sh_div     <= r_baud_div;
    end
  end

endmodule
